// File: rtl/draw_player_if.sv
// VGA stream bundle shared by the background and sprite stages.
// One modport per direction of travel through a stage.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount,
        input vsync,
        input vblnk,
        input hcount,
        input hsync,
        input hblnk,
        input rgb
    );

    modport out (
        output vcount,
        output vsync,
        output vblnk,
        output hcount,
        output hsync,
        output hblnk,
        output rgb
    );
endinterface

// File: rtl/draw_player.sv
// Player sprite overlay: 3-clk pipeline around a 1-cycle sprite ROM.
// Position/facing/blink are latched on vblnk rise so a frame never tears.
module draw_player #(
    parameter int          SPRITE_W    = 48,
    parameter int          SPRITE_H    = 64,
    parameter int          ADDR_W      = 12,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       pos_x,
    input  logic [10:0]       pos_y,
    input  logic              facing_left,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] pixel_addr,
    input  logic [11:0]       rom_rgb,
    vga_if.in                 vga_in,
    vga_if.out                vga_out
);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    vga_t s0;
    vga_t d1;
    vga_t d2;

    logic [10:0] px_q;
    logic [10:0] py_q;
    logic        face_q;
    logic        blink_q;
    logic [2:0]  frame_cnt;
    logic        latched_valid;
    logic        vblnk_prev;
    logic        show_d1;
    logic        show_d2;

    logic              vblnk_rise;
    logic [11:0]       x_end;
    logic [11:0]       y_end;
    logic              in_spr;
    logic              show;
    logic [10:0]       rel_x;
    logic [10:0]       rel_y;
    logic [10:0]       col;
    logic [ADDR_W-1:0] addr_c;

    always_comb begin
        s0 = '{
            vcount: vga_in.vcount,
            vsync:  vga_in.vsync,
            vblnk:  vga_in.vblnk,
            hcount: vga_in.hcount,
            hsync:  vga_in.hsync,
            hblnk:  vga_in.hblnk,
            rgb:    vga_in.rgb
        };
    end

    assign vblnk_rise = vga_in.vblnk && !vblnk_prev;

    // 12-bit ends so a sprite near column 2047 cannot wrap to column 0
    assign x_end = {1'b0, px_q} + 12'(SPRITE_W);
    assign y_end = {1'b0, py_q} + 12'(SPRITE_H);

    assign in_spr = !vga_in.hblnk && !vga_in.vblnk &&
                    ({1'b0, vga_in.hcount} >= {1'b0, px_q}) &&
                    ({1'b0, vga_in.hcount} <  x_end) &&
                    ({1'b0, vga_in.vcount} >= {1'b0, py_q}) &&
                    ({1'b0, vga_in.vcount} <  y_end);

    assign rel_x = vga_in.hcount - px_q;
    assign rel_y = vga_in.vcount - py_q;
    assign col   = face_q ? (11'(SPRITE_W - 1) - rel_x) : rel_x;

    assign addr_c = ADDR_W'(rel_y) * ADDR_W'(SPRITE_W) + ADDR_W'(col);

    // latched_valid keeps the reset-time origin position from drawing
    assign show = in_spr && latched_valid && !(blink_q && frame_cnt[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q           <= '0;
            py_q           <= '0;
            face_q         <= 1'b0;
            blink_q        <= 1'b0;
            frame_cnt      <= '0;
            latched_valid  <= 1'b0;
            vblnk_prev     <= 1'b0;
            d1             <= '0;
            d2             <= '0;
            show_d1        <= 1'b0;
            show_d2        <= 1'b0;
            pixel_addr     <= '0;
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            if (vblnk_rise) begin
                px_q          <= pos_x;
                py_q          <= pos_y;
                face_q        <= facing_left;
                blink_q       <= blink_en;
                frame_cnt     <= frame_cnt + 3'd1;
                latched_valid <= 1'b1;
            end

            d1         <= s0;
            show_d1    <= show;
            pixel_addr <= in_spr ? addr_c : '0;

            d2      <= d1;
            show_d2 <= show_d1;

            vga_out.vcount <= d2.vcount;
            vga_out.vsync  <= d2.vsync;
            vga_out.vblnk  <= d2.vblnk;
            vga_out.hcount <= d2.hcount;
            vga_out.hsync  <= d2.hsync;
            vga_out.hblnk  <= d2.hblnk;
            vga_out.rgb    <= (show_d2 && rom_rgb != TRANSPARENT) ?
                              rom_rgb : d2.rgb;
        end
    end

endmodule
